// File: rtl/c5efa7_fpga_bup_qsys_cpu_div_cell.sv
// c5efa7_fpga_bup_qsys_cpu_div_cell
//   Iterative 32-bit radix-2 restoring divider for the CPU datapath.
//   One quotient bit per clock; fixed 34-cycle latency from start to done.
//
// Ports
//   clk               CPU clock, rising edge
//   reset             asynchronous active-high reset
//   A_div_src1        dividend
//   A_div_src2        divisor
//   A_div_start       request, sampled only while idle
//   A_div_signed      1 = two's-complement operands, sampled with start
//   A_div_rem_sel     1 = return remainder, 0 = quotient, sampled with start
//   A_div_busy        high while an operation is in flight
//   A_div_done        one-cycle pulse, result valid
//   A_div_cell_result quotient or remainder, held until next completion
//   A_div_by_zero     divisor was zero, held with result
module c5efa7_fpga_bup_qsys_cpu_div_cell (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A_div_src1,
   input  logic [31:0] A_div_src2,
   input  logic        A_div_start,
   input  logic        A_div_signed,
   input  logic        A_div_rem_sel,
   output logic        A_div_busy,
   output logic        A_div_done,
   output logic [31:0] A_div_cell_result,
   output logic        A_div_by_zero
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state;
   logic [32:0] rem;        // partial remainder
   logic [31:0] quo;        // dividend magnitude shifting out, quotient bits shifting in
   logic [31:0] dvs_mag;    // divisor magnitude
   logic [31:0] src1_raw;   // original dividend, returned as remainder on divide by zero
   logic [4:0]  count;
   logic        rem_sel;
   logic        q_neg;
   logic        r_neg;
   logic        zero;

   // Operand magnitudes. Negating 0x80000000 yields 0x80000000, which is the
   // correct magnitude when read as unsigned.
   logic [31:0] src1_mag;
   logic [31:0] src2_mag;

   assign src1_mag = (A_div_signed && A_div_src1[31]) ? (~A_div_src1 + 32'd1) : A_div_src1;
   assign src2_mag = (A_div_signed && A_div_src2[31]) ? (~A_div_src2 + 32'd1) : A_div_src2;

   // One restoring step. The remainder never exceeds the divisor magnitude,
   // so the shifted value fits in 33 bits and bit 33 of the trial is the sign.
   logic [33:0] shifted;
   logic [33:0] trial;
   logic        trial_neg;

   assign shifted   = {rem, quo[31]};
   assign trial     = shifted - {2'b00, dvs_mag};
   assign trial_neg = trial[33];

   // Final sign correction, evaluated during FIX.
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic [31:0] result_nxt;

   assign q_fix = q_neg ? (~quo + 32'd1) : quo;
   assign r_fix = r_neg ? (~rem[31:0] + 32'd1) : rem[31:0];

   always_comb begin
      result_nxt = rem_sel ? r_fix : q_fix;
      if (zero)
         result_nxt = rem_sel ? src1_raw : 32'hFFFF_FFFF;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         rem               <= '0;
         quo               <= '0;
         dvs_mag           <= '0;
         src1_raw          <= '0;
         count             <= '0;
         rem_sel           <= 1'b0;
         q_neg             <= 1'b0;
         r_neg             <= 1'b0;
         zero              <= 1'b0;
         A_div_busy        <= 1'b0;
         A_div_done        <= 1'b0;
         A_div_cell_result <= '0;
         A_div_by_zero     <= 1'b0;
      end else begin
         A_div_done <= 1'b0;
         case (state)
            IDLE: begin
               if (A_div_start) begin
                  rem        <= '0;
                  quo        <= src1_mag;
                  dvs_mag    <= src2_mag;
                  src1_raw   <= A_div_src1;
                  count      <= 5'd31;
                  rem_sel    <= A_div_rem_sel;
                  q_neg      <= A_div_signed & (A_div_src1[31] ^ A_div_src2[31]);
                  r_neg      <= A_div_signed & A_div_src1[31];
                  zero       <= (A_div_src2 == 32'd0);
                  A_div_busy <= 1'b1;
                  state      <= RUN;
               end
            end
            RUN: begin
               // Restore by keeping the shifted value when the trial goes negative.
               rem   <= trial_neg ? shifted[32:0] : trial[32:0];
               quo   <= {quo[30:0], ~trial_neg};
               count <= count - 5'd1;
               if (count == 5'd0)
                  state <= FIX;
            end
            FIX: begin
               A_div_cell_result <= result_nxt;
               A_div_by_zero     <= zero;
               A_div_done        <= 1'b1;
               A_div_busy        <= 1'b0;
               state             <= IDLE;
            end
            default: begin
               A_div_busy <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_c5efa7_fpga_bup_qsys_cpu_div_cell.sv
module tb_c5efa7_fpga_bup_qsys_cpu_div_cell;

   logic        clk;
   logic        rst;
   logic [31:0] src1, src2;
   logic        start, sgn, rsel;
   logic        busy, done, bz;
   logic [31:0] res;

   c5efa7_fpga_bup_qsys_cpu_div_cell dut (
      .clk(clk), .reset(rst),
      .A_div_src1(src1), .A_div_src2(src2),
      .A_div_start(start), .A_div_signed(sgn), .A_div_rem_sel(rsel),
      .A_div_busy(busy), .A_div_done(done),
      .A_div_cell_result(res), .A_div_by_zero(bz)
   );

   typedef struct {
      logic [31:0] res;
      logic        bz;
      int          issue;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   // Reference: 64-bit arithmetic so the signed overflow case needs no special handling.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sg, input logic rs, input int t);
      exp_t   e;
      longint la, lb, q, r;
      e.issue = t;
      if (b == 32'd0) begin
         e.bz  = 1'b1;
         e.res = rs ? a : 32'hFFFF_FFFF;
      end else begin
         la    = sg ? longint'($signed(a)) : longint'({32'd0, a});
         lb    = sg ? longint'($signed(b)) : longint'({32'd0, b});
         q     = la / lb;
         r     = la % lb;
         e.bz  = 1'b0;
         e.res = rs ? r[31:0] : q[31:0];
      end
      return e;
   endfunction

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (sb.size() > 0)
            chk("busy", {31'd0, busy},
                {31'd0, (cyc > sb[0].issue) && (cyc <= sb[0].issue + 33)});
         if (done) begin
            if (sb.size() == 0) begin
               chk("stray_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result", res, e.res);
               chk("by_zero", {31'd0, bz}, {31'd0, e.bz});
               chk("latency", cyc - e.issue, 32'd34);
            end
         end
      end
   end

   task automatic wait_empty();
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         chk("timeout", sb.size(), 32'd0);
         sb.delete();
      end
      @(posedge clk);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic rs);
      @(posedge clk); #1;
      src1 = a; src2 = b; sgn = sg; rsel = rs; start = 1'b1;
      sb.push_back(model(a, b, sg, rs, cyc));
      @(posedge clk); #1;
      start = 1'b0;
      // Operands are free to change once sampled.
      src1 = $urandom; src2 = $urandom; sgn = ~sg; rsel = ~rs;
   endtask

   task automatic run(input logic [31:0] a, input logic [31:0] b,
                      input logic sg, input logic rs);
      issue(a, b, sg, rs);
      wait_empty();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst = 1'b1; start = 1'b0; src1 = '0; src2 = '0; sgn = 1'b0; rsel = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_done",   {31'd0, done}, 32'd0);
      chk("rst_result", res,           32'd0);
      chk("rst_bz",     {31'd0, bz},   32'd0);
      rst = 1'b0;

      // Directed cases
      run(32'd100,       32'd7,         1'b0, 1'b0);
      run(32'd100,       32'd7,         1'b0, 1'b1);
      run(32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0);
      run(32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1);
      run(32'd7,         32'hFFFF_FFFE, 1'b1, 1'b0);
      run(32'd7,         32'hFFFF_FFFE, 1'b1, 1'b1);
      run(32'hFFFF_FFF9, 32'd0,         1'b1, 1'b0);
      run(32'hFFFF_FFF9, 32'd0,         1'b1, 1'b1);
      run(32'd5,         32'd0,         1'b0, 1'b0);
      run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
      run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
      run(32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0);
      run(32'h8000_0000, 32'd3,         1'b0, 1'b1);
      run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

      // Start held high: one completion at +34, second operation accepted there.
      @(posedge clk); #1;
      src1 = 32'd100; src2 = 32'd7; sgn = 1'b0; rsel = 1'b0; start = 1'b1;
      t = cyc;
      sb.push_back(model(32'd100, 32'd7, 1'b0, 1'b0, t));
      @(posedge clk); #1;
      src1 = 32'hFFFF_FFF9; src2 = 32'd2; sgn = 1'b1; rsel = 1'b1;
      repeat (33) @(posedge clk);
      #1;
      sb.push_back(model(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, t + 34));
      @(posedge clk); #1;
      start = 1'b0;
      wait_empty();

      // Reset mid-operation aborts with no done.
      issue(32'd1000, 32'd3, 1'b0, 1'b0);
      while (cyc < sb[0].issue + 15) @(posedge clk);
      #1;
      rst = 1'b1;
      sb.delete();
      #1;
      chk("mid_rst_busy",   {31'd0, busy}, 32'd0);
      chk("mid_rst_done",   {31'd0, done}, 32'd0);
      chk("mid_rst_result", res,           32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run(32'd100, 32'd7, 1'b0, 1'b0);

      // Random mix
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
         run(a, b, 1'((i % 2) != 0), 1'(((i / 2) % 2) != 0));
      end

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/c5efa7_fpga_bup_qsys_cpu_div_cell.md
# c5efa7_fpga_bup_qsys_cpu_div_cell

Iterative 32-bit integer divider cell for the Nios-class CPU datapath. It is the inverse-operation companion to the CPU multiply cell: the multiplier yields the low 32 bits of a product, and this block yields a quotient or remainder from a dividend and divisor. It uses radix-2 restoring division, one quotient bit per clock, with a start/done handshake toward the CPU A-stage stall logic. It supports signed and unsigned modes with defined divide-by-zero and overflow results.

## Interface
- No parameters; datapath width fixed at 32.
- clk  input  1  CPU clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- A_div_src1  input  32  dividend.
- A_div_src2  input  32  divisor.
- A_div_start  input  1  request; sampled only in IDLE.
- A_div_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- A_div_rem_sel  input  1  1 = return remainder, 0 = return quotient; sampled with start.
- A_div_busy  output  1  high while an operation is in flight (state != IDLE).
- A_div_done  output  1  one-cycle pulse; result valid.
- A_div_cell_result  output  32  quotient or remainder; held until next completion.
- A_div_by_zero  output  1  divisor was zero; valid with done, held with result.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: if A_div_start=1, register the operands, signed, rem_sel, sign flags (q_neg = signed & (src1[31]^src2[31]), r_neg = signed & src1[31]), zero flag (src2==0), and magnitudes (two's-complement absolute value when signed, else raw). Clear the 33-bit partial remainder, load count=31, and go to RUN. Start is ignored outside IDLE. No queueing.
- RUN, each cycle: shift {rem, dividend_mag} left by 1, trial = rem - divisor_mag (33-bit). If trial ≥ 0, rem = trial and the new quotient LSB = 1; else the LSB = 0. Decrement count. After the step with count=0, go to FIX. Exactly 32 iterations.
- FIX: select the raw quotient Q or remainder R.
  - Apply negation if q_neg (quotient) or r_neg (remainder).
  - Divide by zero overrides both: quotient = 0xFFFFFFFF in both modes, remainder = original A_div_src1 value.
  - Register the result and A_div_by_zero, pulse done, and return to IDLE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. The magnitude path produces this naturally and no special case is allowed.
- Magnitude of 0x80000000 is 0x80000000 as an unsigned value. The 33-bit remainder path must not truncate it.
- Remainder sign follows the dividend. Quotient truncates toward zero.

## Timing
- Start high in cycle 0 (IDLE) → busy high in cycles 1–33 → done high in cycle 34 only. Result and by_zero are updated at the same edge that raises done.
- Fixed latency of 34 cycles, independent of operand values, including divide by zero (no early termination).
- State in cycle 34 is IDLE, so a start in the done cycle is accepted. Back-to-back throughput is one operation per 34 cycles.
- Operand inputs may change after the start cycle without effect.
- Reset values (asynchronous, immediate): state IDLE, busy 0, done 0, result 0x00000000, by_zero 0, all internal registers 0.
- Reset asserted mid-operation: abort with no done pulse. After deassertion the block is idle and accepts start on the first cycle.
- Done is registered and never combinational from start.

## Test plan
- Unsigned 100 / 7, rem_sel=0 → done in cycle 34, result 0x0000000E. Repeat with rem_sel=1 → 0x00000002, by_zero 0.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD (−3). With rem_sel=1 → 0xFFFFFFFF (−1). Also 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, signed 0xFFFFFFF9 / 0 → quotient 0xFFFFFFFF, by_zero 1. With rem_sel=1 → 0xFFFFFFF9. Latency is still 34 cycles.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 → 0xFFFFFFFF.
- Hold start high through the whole operation with changed operands → exactly one done at cycle 34 with the original result. The new operation starts from cycle 34 and its done lands at cycle 68.
- Assert reset in cycle 15 of an operation → busy and done drop immediately, result reads 0. Then start 100 / 7 → correct result 34 cycles later and no stray done pulse.
